// File: rtl/io_timer_pkg.sv
// Shared definitions for the io_timer peripheral: register offsets within a
// channel block and the packed CONTROL register layout.
package io_timer_pkg;

    localparam int unsigned ChanStride = 16;

    localparam logic [3:0] OffCount   = 4'h0;
    localparam logic [3:0] OffReload  = 4'h4;
    localparam logic [3:0] OffControl = 4'h8;
    localparam logic [3:0] OffStatus  = 4'hC;

    typedef struct packed {
        logic ie;
        logic en;
    } timer_control_t;

    function automatic logic [31:0] control_word(input timer_control_t ctrl);
        return {30'd0, ctrl};
    endfunction

endpackage

// File: rtl/io_bus_interface.sv
// Processor IO bus: single-cycle write strobe, read data returned one cycle later.
interface io_bus_interface;

    logic        write_en;
    logic        read_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;

    modport slave (
        input  write_en,
        input  read_en,
        input  address,
        input  write_data,
        output read_data
    );

    modport master (
        output write_en,
        output read_en,
        output address,
        output write_data,
        input  read_data
    );

endinterface

// File: rtl/io_timer_channel.sv
// One countdown channel: COUNT/RELOAD/CONTROL registers, pending flag and a
// registered interrupt level.
module io_timer_channel
    import io_timer_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           tick_i,
    input  logic           count_we_i,
    input  logic           reload_we_i,
    input  logic           control_we_i,
    input  logic           status_we_i,
    input  logic [31:0]    write_data_i,
    output logic [31:0]    count_o,
    output logic [31:0]    reload_o,
    output timer_control_t control_o,
    output logic           pending_o,
    output logic           irq_o
);

    logic [31:0]    count_q, count_d;
    logic [31:0]    reload_q, reload_d;
    timer_control_t control_q, control_d;
    logic           pending_q, pending_d;
    logic           irq_q, irq_d;
    logic           active;
    logic           expire;

    always_comb begin
        count_d   = count_q;
        reload_d  = reload_q;
        control_d = control_q;
        pending_d = pending_q;
        irq_d     = pending_q & control_q.ie;

        active = tick_i && control_q.en;
        // A software COUNT write on the expiry edge suppresses the expiry entirely.
        expire = active && (count_q == 32'd1) && !count_we_i;

        if (active && (count_q > 32'd1)) begin
            count_d = count_q - 32'd1;
        end else if (expire) begin
            count_d = reload_q;
            if (reload_q == 32'd0) begin
                control_d.en = 1'b0;
            end
        end

        if (count_we_i) begin
            count_d = write_data_i;
        end
        if (reload_we_i) begin
            reload_d = write_data_i;
        end
        if (control_we_i) begin
            control_d = timer_control_t'(write_data_i[1:0]);
        end

        // Set has priority over write-1-to-clear.
        if (status_we_i && write_data_i[0]) begin
            pending_d = 1'b0;
        end
        if (expire) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q   <= '0;
            reload_q  <= '0;
            control_q <= '0;
            pending_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            count_q   <= count_d;
            reload_q  <= reload_d;
            control_q <= control_d;
            pending_q <= pending_d;
            irq_q     <= irq_d;
        end
    end

    assign count_o   = count_q;
    assign reload_o  = reload_q;
    assign control_o = control_q;
    assign pending_o = pending_q;
    assign irq_o     = irq_q;

endmodule

// File: rtl/io_timer.sv
// Multi-channel countdown timer on the IO bus: shared prescaler, address
// decode, registered read port and one io_timer_channel per timer.
module io_timer
    import io_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS = 32'h300,
    parameter int unsigned NUM_TIMERS   = 4,
    parameter int unsigned PRESCALE     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    io_bus_interface.slave        io_bus,
    output logic [NUM_TIMERS-1:0] timer_interrupt
);

    localparam int unsigned PreW = 17;

    logic [PreW-1:0] presc_q, presc_d;
    logic            tick;

    logic            in_range;
    logic [1:0]      chan_sel;
    logic [3:0]      reg_off;

    logic [31:0]     count_a   [NUM_TIMERS];
    logic [31:0]     reload_a  [NUM_TIMERS];
    timer_control_t  control_a [NUM_TIMERS];
    logic [NUM_TIMERS-1:0] pending_a;

    logic [31:0]     rd_value;
    logic [31:0]     read_data_q, read_data_d;

    // Prescaler free-runs regardless of bus traffic.
    assign tick = (presc_q == PreW'(PRESCALE - 1));

    always_comb begin
        presc_d = tick ? '0 : presc_q + PreW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    // BASE_ADDRESS is 64-byte aligned, so channel and register come straight
    // from the low address bits once the full-width range check passes.
    assign in_range = (io_bus.address >= BASE_ADDRESS) &&
                      ({1'b0, io_bus.address} <
                       ({1'b0, BASE_ADDRESS} + 33'(NUM_TIMERS * ChanStride)));
    assign chan_sel = io_bus.address[5:4];
    assign reg_off  = {io_bus.address[3:2], 2'b00};

    for (genvar n = 0; n < NUM_TIMERS; n++) begin : g_chan
        logic wr_sel;

        assign wr_sel = io_bus.write_en && in_range && (chan_sel == 2'(n));

        io_timer_channel u_chan (
            .clk          (clk),
            .reset        (reset),
            .tick_i       (tick),
            .count_we_i   (wr_sel && (reg_off == OffCount)),
            .reload_we_i  (wr_sel && (reg_off == OffReload)),
            .control_we_i (wr_sel && (reg_off == OffControl)),
            .status_we_i  (wr_sel && (reg_off == OffStatus)),
            .write_data_i (io_bus.write_data),
            .count_o      (count_a[n]),
            .reload_o     (reload_a[n]),
            .control_o    (control_a[n]),
            .pending_o    (pending_a[n]),
            .irq_o        (timer_interrupt[n])
        );
    end

    always_comb begin
        rd_value = '0;
        for (int n = 0; n < NUM_TIMERS; n++) begin
            if (in_range && (chan_sel == 2'(n))) begin
                unique case (reg_off)
                    OffCount:   rd_value = count_a[n];
                    OffReload:  rd_value = reload_a[n];
                    OffControl: rd_value = control_word(control_a[n]);
                    default:    rd_value = {31'd0, pending_a[n]};
                endcase
            end
        end
    end

    // Sampled before the write edge lands, so a simultaneous write is not visible.
    always_comb begin
        read_data_d = io_bus.read_en ? rd_value : read_data_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            read_data_q <= '0;
        end else begin
            read_data_q <= read_data_d;
        end
    end

    assign io_bus.read_data = read_data_q;

endmodule

// File: tb/tb_io_timer.sv
// Self-checking bench for io_timer: register table, directed corner cases on
// PRESCALE=1 and PRESCALE=4 instances, reset behaviour and a randomized run.
module tb_io_timer;

    localparam logic [31:0] Base = 32'h300;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        we   [2];
    logic        re   [2];
    logic [31:0] addr [2];
    logic [31:0] wdat [2];
    logic [3:0]  irq1;
    logic [1:0]  irq4;

    io_bus_interface bus1 ();
    io_bus_interface bus4 ();

    assign bus1.write_en   = we[0];
    assign bus1.read_en    = re[0];
    assign bus1.address    = addr[0];
    assign bus1.write_data = wdat[0];
    assign bus4.write_en   = we[1];
    assign bus4.read_en    = re[1];
    assign bus4.address    = addr[1];
    assign bus4.write_data = wdat[1];

    io_timer #(.BASE_ADDRESS(Base), .NUM_TIMERS(4), .PRESCALE(1)) dut1 (
        .clk             (clk),
        .reset           (reset),
        .io_bus          (bus1),
        .timer_interrupt (irq1)
    );

    io_timer #(.BASE_ADDRESS(Base), .NUM_TIMERS(2), .PRESCALE(4)) dut4 (
        .clk             (clk),
        .reset           (reset),
        .io_bus          (bus4),
        .timer_interrupt (irq4)
    );

    int total = 0;
    int bad   = 0;

    // Index of the next clock edge since reset release; the prescaler phase follows it.
    int unsigned edge_n;
    always @(posedge clk or posedge reset) begin
        if (reset) edge_n <= 0;
        else       edge_n <= edge_n + 1;
    end

    // Behavioural reference model for the randomized phase.
    bit          model_on = 1'b0;
    int          md;
    int unsigned mP, mN;
    logic [31:0] m_cnt [4];
    logic [31:0] m_rld [4];
    bit          m_en  [4];
    bit          m_ie  [4];
    bit          m_pend[4];
    logic [3:0]  m_irq;
    logic [31:0] m_rdata;

    typedef struct {
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [31:0] raddr;
        logic [31:0] want;
        string       name;
    } vec_t;
    vec_t vecs [9];

    logic [31:0] rv;
    logic [31:0] a_r, v_r;
    int          op, ch_r, reg_r;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    function automatic logic [31:0] irqv(input int d);
        return (d == 0) ? {28'd0, irq1} : {30'd0, irq4};
    endfunction

    function automatic logic [31:0] m_read(input int ch, input int r);
        case (r)
            0:       return m_cnt[ch];
            1:       return m_rld[ch];
            2:       return {30'd0, m_ie[ch], m_en[ch]};
            default: return {31'd0, m_pend[ch]};
        endcase
    endfunction

    task automatic model_step(input bit tk);
        logic [31:0] a;
        bit          hit;
        int          ch, r;
        logic [3:0]  nirq;
        a    = addr[md];
        hit  = (a >= Base) && (a < Base + 32'(mN * 16));
        ch   = hit ? int'((a - Base) / 16) : 0;
        r    = int'(((a - Base) % 16) / 4);
        nirq = '0;
        for (int i = 0; i < int'(mN); i++) nirq[i] = m_pend[i] & m_ie[i];
        if (re[md]) m_rdata = hit ? m_read(ch, r) : 32'd0;
        for (int i = 0; i < int'(mN); i++) begin
            bit cw, expire;
            cw     = we[md] && hit && (ch == i);
            expire = tk && m_en[i] && (m_cnt[i] == 1) && !(cw && r == 0);
            if (tk && m_en[i] && m_cnt[i] > 1) begin
                m_cnt[i] = m_cnt[i] - 1;
            end else if (expire) begin
                m_cnt[i] = m_rld[i];
                if (m_rld[i] == 0) m_en[i] = 1'b0;
            end
            if (cw) begin
                case (r)
                    0: m_cnt[i] = wdat[md];
                    1: m_rld[i] = wdat[md];
                    2: begin m_en[i] = wdat[md][0]; m_ie[i] = wdat[md][1]; end
                    default: if (wdat[md][0]) m_pend[i] = 1'b0;
                endcase
            end
            if (expire) m_pend[i] = 1'b1;
        end
        m_irq = nirq;
    endtask

    task automatic cyc();
        int unsigned k;
        k = edge_n;
        @(posedge clk);
        if (model_on) model_step((k % mP) == mP - 1);
        #1;
    endtask

    task automatic wr(input int d, input logic [31:0] a, input logic [31:0] v);
        we[d] = 1'b1; addr[d] = a; wdat[d] = v;
        cyc();
        we[d] = 1'b0;
    endtask

    task automatic rd(input int d, input logic [31:0] a, output logic [31:0] v);
        re[d] = 1'b1; addr[d] = a;
        cyc();
        re[d] = 1'b0;
        v = (d == 0) ? bus1.read_data : bus4.read_data;
    endtask

    task automatic rd_chk(input int d, input logic [31:0] a, input logic [31:0] want,
                          input string name);
        logic [31:0] v;
        rd(d, a, v);
        check(name, v, want);
    endtask

    task automatic align(input int unsigned m);
        for (int i = 0; i < 4 && (edge_n % 4) != m; i++) cyc();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{Base + 32'h00, 32'h1234_5678, Base + 32'h00, 32'h1234_5678, "tbl count"};
        vecs[1] = '{Base + 32'h04, 32'hdead_beef, Base + 32'h04, 32'hdead_beef, "tbl reload"};
        vecs[2] = '{Base + 32'h08, 32'hffff_fffc, Base + 32'h08, 32'h0,         "tbl ctrl"};
        vecs[3] = '{Base + 32'h1c, 32'h1,         Base + 32'h1c, 32'h0,         "tbl status"};
        vecs[4] = '{Base + 32'h34, 32'h55,        Base + 32'h34, 32'h55,        "tbl ch3"};
        vecs[5] = '{Base + 32'h40, 32'hffff_ffff, Base + 32'h40, 32'h0,         "tbl past end"};
        vecs[6] = '{32'h100,       32'h1,         32'h100,       32'h0,         "tbl 0x100"};
        vecs[7] = '{Base + 32'h21, 32'h77,        Base + 32'h22, 32'h77,        "tbl byte bits"};
        vecs[8] = '{Base - 32'h4,  32'h5,         Base - 32'h4,  32'h0,         "tbl below"};

        for (int d = 0; d < 2; d++) begin
            we[d] = 1'b0; re[d] = 1'b0; addr[d] = '0; wdat[d] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("irq in reset", irqv(0), 32'd0);
        reset = 1'b0;

        // Reset values of every register.
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                rd_chk(0, Base + 32'(c * 16 + r * 4), 32'd0, "reset reg dut1");
        for (int c = 0; c < 2; c++)
            for (int r = 0; r < 4; r++)
                rd_chk(1, Base + 32'(c * 16 + r * 4), 32'd0, "reset reg dut4");
        check("reset irq dut1", irqv(0), 32'd0);
        check("reset irq dut4", irqv(1), 32'd0);

        foreach (vecs[i]) begin
            wr(0, vecs[i].waddr, vecs[i].wdata);
            rd_chk(0, vecs[i].raddr, vecs[i].want, vecs[i].name);
        end
        rd_chk(0, Base, 32'h1234_5678, "no alias write");

        // Back-to-back reads across channels, then hold.
        rd_chk(0, Base + 32'h04, 32'hdead_beef, "b2b ch0");
        rd_chk(0, Base + 32'h34, 32'h55, "b2b ch3");
        rd_chk(0, Base + 32'h20, 32'h77, "b2b ch2");
        cyc();
        check("read hold", bus1.read_data, 32'h77);

        // Simultaneous read and write returns the pre-write value.
        we[0] = 1'b1; re[0] = 1'b1; addr[0] = Base + 32'h30; wdat[0] = 32'h9;
        cyc();
        we[0] = 1'b0; re[0] = 1'b0;
        check("rw same cycle", bus1.read_data, 32'h0);
        rd_chk(0, Base + 32'h30, 32'h9, "rw after");

        // One-shot on channel 0, PRESCALE=1.
        wr(0, Base + 32'h4, 0);
        wr(0, Base + 32'h0, 5);
        wr(0, Base + 32'h8, 3);
        for (int i = 0; i < 4; i++) rd_chk(0, Base, 32'(5 - i), "oneshot count");
        cyc();
        check("oneshot irq early", irqv(0) & 1, 32'd0);
        cyc();
        check("oneshot irq rise", irqv(0) & 1, 32'd1);
        rd_chk(0, Base + 32'h0, 32'd0, "oneshot count end");
        rd_chk(0, Base + 32'h8, 32'd2, "oneshot en cleared");
        rd_chk(0, Base + 32'hc, 32'd1, "oneshot pending");
        wr(0, Base + 32'hc, 1);
        check("irq after clr edge", irqv(0) & 1, 32'd1);
        cyc();
        check("irq dropped", irqv(0) & 1, 32'd0);

        // Periodic on channel 1.
        wr(0, Base + 32'h14, 3);
        wr(0, Base + 32'h10, 3);
        wr(0, Base + 32'h18, 1);
        for (int i = 0; i < 6; i++) rd_chk(0, Base + 32'h10, 32'(3 - (i % 3)), "periodic count");
        cyc();
        cyc();
        wr(0, Base + 32'h1c, 1);
        rd_chk(0, Base + 32'h1c, 32'd1, "clear vs expiry");
        wr(0, Base + 32'h1c, 1);
        rd_chk(0, Base + 32'h1c, 32'd0, "plain clear");
        wr(0, Base + 32'h18, 0);

        // PRESCALE=4: expiry 8 cycles after the enable edge, enable on a tick edge.
        wr(1, Base, 2);
        align(3);
        wr(1, Base + 32'h8, 3);
        repeat (7) cyc();
        rd_chk(1, Base + 32'hc, 32'd0, "p4 before expiry");
        check("p4 irq early", irqv(1) & 1, 32'd0);
        rd_chk(1, Base + 32'hc, 32'd1, "p4 expiry");
        check("p4 irq", irqv(1) & 1, 32'd1);

        wr(1, Base + 32'h10, 2);
        align(3);
        wr(1, Base + 32'h18, 3);
        repeat (7) cyc();
        wr(1, Base + 32'h10, 7);
        rd_chk(1, Base + 32'h10, 32'd7, "p4 count write wins");
        rd_chk(1, Base + 32'h1c, 32'd0, "p4 no pending");
        rd_chk(1, Base + 32'h18, 32'd3, "p4 en kept");
        check("p4 irq1 low", irqv(1) & 2, 32'd0);

        // Reset while three channels count with interrupts pending.
        for (int c = 0; c < 3; c++) begin
            wr(0, Base + 32'(c * 16 + 4), 2);
            wr(0, Base + 32'(c * 16), 2);
            wr(0, Base + 32'(c * 16 + 8), 3);
        end
        repeat (4) cyc();
        check("irqs before reset", irqv(0), 32'h7);
        rd_chk(0, Base + 32'h4, 32'd2, "rdata before reset");
        #2;
        reset = 1'b1;
        #1;
        check("async irq dut1", irqv(0), 32'd0);
        check("async rdata dut1", bus1.read_data, 32'd0);
        check("async irq dut4", irqv(1), 32'd0);
        check("async rdata dut4", bus4.read_data, 32'd0);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("irq held in reset", irqv(0), 32'd0);
        end
        reset = 1'b0;
        repeat (10) cyc();
        check("no resume irq", irqv(0), 32'd0);
        rd_chk(0, Base + 32'h00, 32'd0, "post reset count0");
        rd_chk(0, Base + 32'h08, 32'd0, "post reset ctrl0");
        rd_chk(0, Base + 32'h10, 32'd0, "post reset count1");
        rd_chk(0, Base + 32'h20, 32'd0, "post reset count2");

        // Randomized run against the reference model on each instance.
        for (int d = 0; d < 2; d++) begin
            md = d;
            mP = (d == 0) ? 1 : 4;
            mN = (d == 0) ? 4 : 2;
            for (int i = 0; i < 4; i++) begin
                m_cnt[i] = '0; m_rld[i] = '0; m_en[i] = 0; m_ie[i] = 0; m_pend[i] = 0;
            end
            m_irq   = '0;
            m_rdata = '0;
            model_on = 1'b1;
            for (int n = 0; n < 400; n++) begin
                op    = $urandom_range(0, 9);
                ch_r  = $urandom_range(0, mN);
                reg_r = $urandom_range(0, 3);
                a_r   = Base + 32'(ch_r * 16 + reg_r * 4) + 32'($urandom_range(0, 3));
                if ($urandom_range(0, 19) == 0) a_r = 32'h100 + 32'(reg_r * 4);
                case (reg_r)
                    0:       v_r = 32'($urandom_range(0, 9));
                    1:       v_r = 32'($urandom_range(0, 4));
                    default: v_r = $urandom;
                endcase
                we[d]   = (op <= 3);
                re[d]   = (op >= 3) && (op <= 7);
                addr[d] = a_r;
                wdat[d] = v_r;
                cyc();
                check("rand rdata", (d == 0) ? bus1.read_data : bus4.read_data, m_rdata);
                check("rand irq", irqv(d), 32'(m_irq) & ((32'd1 << mN) - 1));
            end
            we[d] = 1'b0;
            re[d] = 1'b0;
            model_on = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
